// File: rtl/fp_accumulator.sv
// Sequential FP32 accumulator: sums a stream of products using a multi-cycle
// align/add/normalise FSM and presents the result after the operand tagged last.
`timescale 1ns/1ps
module fp_accumulator #(
  parameter int XLEN    = 32,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_sum,
  output logic [COUNT_W-1:0] out_count,
  output logic               overflow,
  underflow
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_FINISH,
    S_DONE
  } state_t;

  function automatic logic [XLEN-1:0] max_finite(input logic sign);
    return {sign, 31'h7F7FFFFF};
  endfunction

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] c);
    if (&c) return c;
    return c + 1'b1;
  endfunction

  state_t               state_q, state_d;
  logic [XLEN-1:0]      acc_q, acc_d;
  logic [XLEN-1:0]      opd_q, opd_d;
  logic                 last_q, last_d;
  logic [COUNT_W-1:0]   cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;
  logic [7:0]           exp_q, exp_d;
  logic [23:0]          mx_q, mx_d;
  logic [23:0]          my_q, my_d;
  logic                 sx_q, sx_d;
  logic                 sy_q, sy_d;
  logic [24:0]          sum_q, sum_d;
  logic                 rs_q, rs_d;

  logic [7:0]           op_exp;
  logic                 op_inf;
  logic                 op_zero;
  logic [XLEN-1:0]      op_word;
  logic                 acc_zero;
  logic                 acc_big;
  logic [7:0]           exp_diff;
  logic [23:0]          small_man;
  logic [23:0]          small_shift;
  logic [7:0]           exp_inc;
  logic [7:0]           exp_dec;

  // Inf/NaN operands are clamped to the largest finite magnitude before use.
  assign op_exp      = opd_q[30:23];
  assign op_inf      = &op_exp;
  assign op_zero     = (op_exp == 8'd0);
  assign op_word     = op_inf ? max_finite(opd_q[31]) : opd_q;
  assign acc_zero    = (acc_q[30:23] == 8'd0);
  assign acc_big     = (acc_q[30:23] >= op_word[30:23]);
  assign exp_diff    = acc_big ? (acc_q[30:23] - op_word[30:23])
                               : (op_word[30:23] - acc_q[30:23]);
  assign small_man   = acc_big ? {1'b1, op_word[22:0]} : {1'b1, acc_q[22:0]};
  assign small_shift = (exp_diff >= 8'd25) ? 24'd0 : (small_man >> exp_diff);
  assign exp_inc     = exp_q + 8'd1;
  assign exp_dec     = exp_q - 8'd1;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    opd_d   = opd_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    exp_d   = exp_q;
    mx_d    = mx_q;
    my_d    = my_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    sum_d   = sum_q;
    rs_d    = rs_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          opd_d   = in_data;
          last_d  = in_last;
          cnt_d   = sat_inc(cnt_q);
          state_d = S_ALIGN;
        end
      end

      S_ALIGN: begin
        if (op_inf) ovf_d = 1'b1;
        if (op_zero) begin
          state_d = S_FINISH;
        end else if (acc_zero) begin
          acc_d   = op_word;
          state_d = S_FINISH;
        end else begin
          exp_d   = acc_big ? acc_q[30:23] : op_word[30:23];
          mx_d    = acc_big ? {1'b1, acc_q[22:0]} : {1'b1, op_word[22:0]};
          sx_d    = acc_big ? acc_q[31] : op_word[31];
          sy_d    = acc_big ? op_word[31] : acc_q[31];
          my_d    = small_shift;
          state_d = S_ADD;
        end
      end

      S_ADD: begin
        if (sx_q == sy_q) begin
          sum_d = {1'b0, mx_q} + {1'b0, my_q};
          rs_d  = sx_q;
        end else if (mx_q >= my_q) begin
          sum_d = {1'b0, mx_q} - {1'b0, my_q};
          rs_d  = sx_q;
        end else begin
          sum_d = {1'b0, my_q} - {1'b0, mx_q};
          rs_d  = sy_q;
        end
        state_d = S_NORM;
      end

      // One shift per cycle; the loop exits when bit 23 is the leading one.
      S_NORM: begin
        if (sum_q == 25'd0) begin
          acc_d   = '0;
          state_d = S_FINISH;
        end else if (sum_q[24]) begin
          sum_d = {1'b0, sum_q[24:1]};
          exp_d = exp_inc;
          if (exp_inc == 8'hFF) begin
            ovf_d   = 1'b1;
            acc_d   = max_finite(rs_q);
            state_d = S_FINISH;
          end
        end else if (!sum_q[23]) begin
          sum_d = {sum_q[23:0], 1'b0};
          exp_d = exp_dec;
          if (exp_dec == 8'd0) begin
            unf_d   = 1'b1;
            acc_d   = '0;
            state_d = S_FINISH;
          end
        end else begin
          acc_d   = {rs_q, exp_q, sum_q[22:0]};
          state_d = S_FINISH;
        end
      end

      S_FINISH: begin
        state_d = last_q ? S_DONE : S_IDLE;
      end

      S_DONE: begin
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      opd_q   <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      exp_q   <= '0;
      mx_q    <= '0;
      my_q    <= '0;
      sx_q    <= 1'b0;
      sy_q    <= 1'b0;
      sum_q   <= '0;
      rs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      opd_q   <= opd_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      exp_q   <= exp_d;
      mx_q    <= mx_d;
      my_q    <= my_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      sum_q   <= sum_d;
      rs_q    <= rs_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_sum   = acc_q;
  assign out_count = cnt_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_fp_accumulator.sv
// Directed bench for fp_accumulator: vector table of operand streams plus
// hand-written timing, backpressure, reset and count-saturation sequences.
`timescale 1ns/1ps
module tb_fp_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic [7:0]  out_count;
  logic        overflow;
  logic        underflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_accumulator #(.XLEN(32), .COUNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  typedef struct {
    string       name;
    int          n;
    logic [31:0] op0;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] sum;
    logic [7:0]  cnt;
    logic        ovf;
    logic        unf;
  } vec_t;

  vec_t vecs[14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && n < 1000) begin
      step();
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1");
    end
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 32'h0;
  endtask

  task automatic wait_ready(output int steps);
    steps = 0;
    while (!in_ready && steps < 1000) begin
      step();
      steps++;
    end
  endtask

  task automatic wait_valid(output int steps);
    steps = 0;
    while (!out_valid && steps < 1000) begin
      step();
      steps++;
    end
  endtask

  task automatic get_result(input string name, input logic [31:0] sum, input logic [7:0] cnt,
                            input logic ovf, input logic unf);
    int s;
    wait_valid(s);
    chk({name, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({name, "_sum"}, out_sum, sum);
    chk({name, "_cnt"}, {24'b0, out_count}, {24'b0, cnt});
    chk({name, "_ovf"}, {31'b0, overflow}, {31'b0, ovf});
    chk({name, "_unf"}, {31'b0, underflow}, {31'b0, unf});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    int s;
    logic [31:0] d;

    vecs[0]  = '{"add_1_2",     2, 32'h3F800000, 32'h40000000, 32'h0, 32'h40400000, 8'd2, 1'b0, 1'b0};
    vecs[1]  = '{"cancel",      2, 32'h3FC00000, 32'hBFC00000, 32'h0, 32'h00000000, 8'd2, 1'b0, 1'b0};
    vecs[2]  = '{"sub_norm",    2, 32'h3F800000, 32'hBF400000, 32'h0, 32'h3E800000, 8'd2, 1'b0, 1'b0};
    vecs[3]  = '{"exp_sat",     3, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h00000001, 32'h7F7FFFFF, 8'd3, 1'b1, 1'b0};
    vecs[4]  = '{"single",      1, 32'h40A00000, 32'h0, 32'h0, 32'h40A00000, 8'd1, 1'b0, 1'b0};
    vecs[5]  = '{"inf_in",      1, 32'h7F800000, 32'h0, 32'h0, 32'h7F7FFFFF, 8'd1, 1'b1, 1'b0};
    vecs[6]  = '{"neginf_one",  2, 32'hFF800000, 32'h3F800000, 32'h0, 32'hFF7FFFFF, 8'd2, 1'b1, 1'b0};
    vecs[7]  = '{"underflow",   2, 32'h00800000, 32'h80C00000, 32'h0, 32'h00000000, 8'd2, 1'b0, 1'b1};
    vecs[8]  = '{"carry",       2, 32'h3FC00000, 32'h3FC00000, 32'h0, 32'h40400000, 8'd2, 1'b0, 1'b0};
    vecs[9]  = '{"trunc_d23",   2, 32'h3F800000, 32'h34400000, 32'h0, 32'h3F800001, 8'd2, 1'b0, 1'b0};
    vecs[10] = '{"far_d25_24",  3, 32'h3F800000, 32'h33000000, 32'h33800000, 32'h3F800000, 8'd3, 1'b0, 1'b0};
    vecs[11] = '{"neg_same",    2, 32'hBF800000, 32'hBF800000, 32'h0, 32'hC0000000, 8'd2, 1'b0, 1'b0};
    vecs[12] = '{"zeros_first", 3, 32'h00000000, 32'h80000000, 32'h40000000, 32'h40000000, 8'd3, 1'b0, 1'b0};
    vecs[13] = '{"neg_result",  2, 32'h3F800000, 32'hC0000000, 32'h0, 32'hBF800000, 8'd2, 1'b0, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;

    chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_sum",       out_sum,            32'h0);
    chk("rst_cnt",       {24'b0, out_count}, 32'd0);
    chk("rst_ovf",       {31'b0, overflow},  32'd0);
    chk("rst_unf",       {31'b0, underflow}, 32'd0);

    // Latency: zero shortcut, accumulator-zero shortcut, plain add.
    send(32'h00000000, 1'b0);
    wait_ready(s);
    chk("lat_zero_op", s, 32'd2);
    send(32'h3F800000, 1'b0);
    wait_ready(s);
    chk("lat_acc_zero", s, 32'd2);
    send(32'h40000000, 1'b1);
    chk("busy_in_ready", {31'b0, in_ready}, 32'd0);
    wait_valid(s);
    chk("lat_to_valid", s, 32'd4);
    get_result("lat_seq", 32'h40400000, 8'd3, 1'b0, 1'b0);

    // Two left shifts in NORM: 2 extra cycles before out_valid.
    send(32'h3F800000, 1'b0);
    send(32'hBF400000, 1'b1);
    wait_valid(s);
    chk("lat_norm2", s, 32'd6);
    get_result("norm2_seq", 32'h3E800000, 8'd2, 1'b0, 1'b0);

    // Carry-out: one extra NORM cycle; non-last operand reopens at T+5.
    send(32'h3F800000, 1'b0);
    send(32'h40000000, 1'b0);
    wait_ready(s);
    chk("lat_next_accept", s, 32'd4);
    send(32'hC0400000, 1'b0);
    send(32'h3FC00000, 1'b0);
    send(32'h3FC00000, 1'b1);
    wait_valid(s);
    chk("lat_carry", s, 32'd5);
    get_result("carry_seq", 32'h40400000, 8'd5, 1'b0, 1'b0);

    // Backpressure in DONE with junk offered on the input.
    send(32'h3F800000, 1'b0);
    send(32'h40000000, 1'b1);
    wait_valid(s);
    in_valid = 1'b1;
    in_data  = 32'h12345678;
    in_last  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid",    {31'b0, out_valid}, 32'd1);
      chk("hold_sum",      out_sum,            32'h40400000);
      chk("hold_cnt",      {24'b0, out_count}, 32'd2);
      chk("hold_in_ready", {31'b0, in_ready},  32'd0);
      step();
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("post_hs_in_ready",  {31'b0, in_ready},  32'd1);
    chk("post_hs_out_valid", {31'b0, out_valid}, 32'd0);
    chk("post_hs_sum",       out_sum,            32'h0);
    chk("post_hs_cnt",       {24'b0, out_count}, 32'd0);
    send(32'h40A00000, 1'b1);
    get_result("after_hs", 32'h40A00000, 8'd1, 1'b0, 1'b0);

    // Reset during NORM aborts the sum.
    send(32'h7F800000, 1'b0);
    send(32'hBF400000, 1'b1);
    step();
    step();
    chk("norm_busy", {31'b0, in_ready}, 32'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_in_ready",  {31'b0, in_ready},  32'd1);
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_sum",       out_sum,            32'h0);
    chk("midrst_cnt",       {24'b0, out_count}, 32'd0);
    chk("midrst_ovf",       {31'b0, overflow},  32'd0);
    chk("midrst_unf",       {31'b0, underflow}, 32'd0);

    for (int v = 0; v < 14; v++) begin
      for (int k = 0; k < vecs[v].n; k++) begin
        d = (k == 0) ? vecs[v].op0 : ((k == 1) ? vecs[v].op1 : vecs[v].op2);
        send(d, (k == vecs[v].n - 1));
      end
      get_result(vecs[v].name, vecs[v].sum, vecs[v].cnt, vecs[v].ovf, vecs[v].unf);
    end

    // Operand count saturates at 255.
    for (int k = 0; k < 260; k++) begin
      send(32'h00000000, (k == 259));
    end
    get_result("cnt_sat", 32'h00000000, 8'd255, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_accumulator.md
# fp_accumulator

Sequential IEEE-754 single-precision accumulator that sits directly downstream of the FP32 multiplier in the neuron datapath. It consumes a stream of weight×input products over a valid/ready handshake and sums them into a running accumulator. It then presents the weighted sum for the neuron's activation stage once the operand tagged `in_last` has been added. It uses a multi-cycle align/add/normalise state machine instead of a combinational adder, which keeps the datapath small.

## Interface
- `XLEN`, 32: operand and result width. Only 32 is supported.
- `COUNT_W`, 8: width of the operand counter.

- `clk`  in  1  clock. All logic is on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  product operand valid.
- `in_ready`  out  1  operand accepted when `in_valid && in_ready`. Equals 1 exactly in state IDLE.
- `in_data`  in  XLEN  FP32 product from the multiplier.
- `in_last`  in  1  marks the final operand of a sum. Sampled with `in_data`.
- `out_valid`  out  1  sum valid. Equals 1 exactly in state DONE.
- `out_ready`  in  1  downstream accepts the sum.
- `out_sum`  out  XLEN  accumulated FP32 sum. Equals the accumulator register.
- `out_count`  out  COUNT_W  operands in this sum. Saturates at 2^COUNT_W−1.
- `overflow`  out  1  sticky per sum. Set on exponent saturation or an exp=255 input.
- `underflow`  out  1  sticky per sum. Set when normalisation flushes a nonzero result to 0.

## Operation
- State machine: IDLE → ALIGN → ADD → NORM → FINISH → (IDLE | DONE) → IDLE.
- **IDLE**
  - On handshake, latch `in_data` and `in_last` into operand registers.
  - Increment the count, then go to ALIGN.
- **Operand classes**
  - Exponent 0 means ±0; denormals are flushed.
  - Exponent 255 (inf/NaN) sets `overflow` and is treated as ±0x7F7FFFFF with its sign.
  - Mantissa is {1, frac} (24 bits).
- **ALIGN**
  - Operand zero: accumulator unchanged, go to FINISH.
  - Accumulator zero: accumulator ← operand, go to FINISH.
  - Otherwise, select the larger exponent, d = |ea − eb|, and shift the smaller mantissa right by d in one cycle.
  - If d ≥ 25, the shifted mantissa is 0.
  - Shifted-out bits are truncated; there is no rounding.
- **ADD** (25-bit result)
  - Equal signs: add the mantissas; sign is the common sign.
  - Unequal signs: subtract the smaller magnitude from the larger; sign is that of the larger.
  - Equal magnitudes give +0.
- **NORM**: one action per cycle.
  - Sum = 0: accumulator ← +0, go to FINISH.
  - Bit 24 set: shift right 1 and increment the exponent. If the exponent reaches 255, set `overflow`, accumulator ← {sign, 0x7F7FFFFF[30:0]}, go to FINISH.
  - Bit 23 clear: shift left 1 and decrement the exponent. If the exponent reaches 0, accumulator ← +0, set `underflow`, go to FINISH.
  - Bit 23 set and bit 24 clear: write {sign, exp, sum[22:0]} to the accumulator, go to FINISH.
- **FINISH**: go to DONE if the latched last flag is 1, else go to IDLE.
- **DONE**
  - Hold `out_sum`, `out_count`, `overflow` and `underflow` stable until `out_ready`.
  - On the handshake cycle, clear the accumulator, count and flags, then go to IDLE.
- **Reset**: `rst_n` = 0 at any state (including mid-NORM) aborts the operation. The next state is IDLE with all registers cleared.

## Timing
- Reset values:
  - `in_ready` = 1 (state IDLE).
  - `out_valid` = 0, `out_sum` = 0x00000000, `out_count` = 0.
  - `overflow` = 0, `underflow` = 0.
- Accept at cycle T: ALIGN at T+1, ADD at T+2, NORM from T+3.
- NORM length:
  - 1 cycle with no shift.
  - 2 cycles on carry-out.
  - k+1 cycles for k left shifts (k ≤ 23).
- FINISH follows NORM. For an operand with no normalisation shift, the earliest next accept is T+5.
- Zero-operand shortcut: ALIGN at T+1, FINISH at T+2, next accept at T+3.
- `out_valid` rises the cycle after FINISH of the last operand.
- `in_ready` stays 0 throughout ALIGN, ADD, NORM, FINISH and DONE. Inputs are ignored outside IDLE.
- `out_valid` and `out_ready` in the same cycle: handshake completes, and `in_ready` = 1 in the next cycle.

## Test plan
- 0x3F800000 (1.0) followed by 0x40000000 (2.0, last) → `out_sum` 0x40400000, `out_count` 2, flags 0. `out_valid` rises 5 cycles after the second accept.
- 0x3FC00000 then 0xBFC00000 (last) → `out_sum` 0x00000000, `underflow` 0.
- 0x3F800000 then 0xBF400000 (−0.75, last) → `out_sum` 0x3E800000. NORM lasts 3 cycles (2 left shifts).
- 0x7F7FFFFF then 0x7F7FFFFF (last) → `overflow` 1, `out_sum` 0x7F7FFFFF. A 0x00000001 operand is treated as zero and leaves the sum unchanged.
- `out_ready` = 0 for 3 cycles in DONE → `out_valid` = 1, `out_sum` and `out_count` stable, `in_ready` 0. After the handshake, a single 0x40A00000 (last) → `out_sum` 0x40A00000, `out_count` 1.
- `rst_n` = 0 for one cycle during NORM → next cycle `in_ready` 1, `out_valid` 0, `out_sum` 0, `out_count` 0, both flags 0.
